// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access : MEM pipeline stage.
//
// Takes the ex_mem register outputs and performs loads and stores over a
// simple req/ack data bus. Byte lanes are big-endian: byte address offset 0
// lives in bits [31:24]. Load data is sign or zero extended. Misaligned
// accesses raise adel_o (loads/LL) or ades_o (stores/SC). The LL/SC link bit
// lives here. stallreq holds the pipeline while a bus access is outstanding.
// All mem_wb-facing outputs are combinational.
//
// Bus handshake: dbus_req is held high with stable dbus_addr/sel/we/wdata
// until the cycle dbus_ack is seen high. dbus_ack is a one-cycle completion
// pulse and may arrive in the same cycle as the first request. dbus_rdata
// is only meaningful in the dbus_ack cycle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           exception flush from ctrl
//   wd_i/wreg_i     destination register / write enable from ex_mem
//   wdata_i         ALU result for non-memory ops
//   aluop_i         op code
//   mem_addr_i      effective address
//   reg2_i          store data
//   excepttype_i    non-zero when an earlier stage already raised an exception
//   dbus_rdata/ack  bus read data and completion pulse
//   wd_o/wreg_o/wdata_o  results to mem_wb
//   stallreq        stall request to ctrl
//   adel_o/ades_o   load / store address error
//   dbus_*          bus request fields
// ---------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        adel_o,
  output logic        ades_o,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_llbit;
  logic        r_ll;
  logic        r_sc;

  // ---------------- decode ----------------
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_is_ll;
  logic        w_is_sc;
  logic        w_misalign;
  logic        w_exc;
  logic        w_sc_fail;
  logic        w_valid;
  logic [31:0] w_addr;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    unique case (aluop_i)
      OP_LB, OP_LBU:        begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
      OP_LH, OP_LHU:        begin w_is_load  = 1'b1; w_is_half = 1'b1; end
      OP_LW, OP_LL:         begin w_is_load  = 1'b1; w_is_word = 1'b1; end
      OP_SB:                begin w_is_store = 1'b1; w_is_byte = 1'b1; end
      OP_SH:                begin w_is_store = 1'b1; w_is_half = 1'b1; end
      OP_SW, OP_SC:         begin w_is_store = 1'b1; w_is_word = 1'b1; end
      default:              ;
    endcase
    w_is_ll    = (aluop_i == OP_LL);
    w_is_sc    = (aluop_i == OP_SC);
    w_misalign = (w_is_half & mem_addr_i[0]) | (w_is_word & (|mem_addr_i[1:0]));
    w_exc      = |excepttype_i;
    // A failing SC never touches the bus; it just reports 0.
    w_sc_fail  = w_is_sc & ~r_llbit;
    w_valid    = (w_is_load | w_is_store) & ~w_misalign & ~w_exc & ~w_sc_fail;

    w_addr = {mem_addr_i[31:2], 2'b00};
    if (w_is_byte)      w_sel = 4'b1000 >> mem_addr_i[1:0];
    else if (w_is_half) w_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    else                w_sel = 4'b1111;
    if (w_is_byte)      w_wdata = {4{reg2_i[7:0]}};
    else if (w_is_half) w_wdata = {2{reg2_i[15:0]}};
    else                w_wdata = reg2_i;
  end

  // ---------------- load data extension ----------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  always_comb begin
    unique case (mem_addr_i[1:0])
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = mem_addr_i[1] ? r_rdata[15:0] : r_rdata[31:16];
    unique case (aluop_i)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  // ---------------- access completion (drives the link bit) ----------------
  logic w_complete;
  logic w_cpl_ll;
  logic w_cpl_sc;

  always_comb begin
    w_complete = 1'b0;
    w_cpl_ll   = 1'b0;
    w_cpl_sc   = 1'b0;
    if (r_state == S_IDLE && w_valid && !flush && dbus_ack) begin
      w_complete = 1'b1;
      w_cpl_ll   = w_is_ll;
      w_cpl_sc   = w_is_sc;
    end else if (r_state == S_BUSY && dbus_ack && !flush) begin
      w_complete = 1'b1;
      w_cpl_ll   = r_ll;
      w_cpl_sc   = r_sc;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_sel   <= 4'd0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_llbit <= 1'b0;
      r_ll    <= 1'b0;
      r_sc    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!flush && w_valid) begin
            r_addr  <= w_addr;
            r_sel   <= w_sel;
            r_we    <= w_is_store;
            r_wdata <= w_wdata;
            r_ll    <= w_is_ll;
            r_sc    <= w_is_sc;
            if (dbus_ack) begin
              r_rdata <= dbus_rdata;
              r_state <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (dbus_ack) begin
            r_rdata <= dbus_rdata;
            // A flush landing on the ack cycle leaves nothing to drain.
            r_state <= flush ? S_IDLE : S_DONE;
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_DRAIN: if (dbus_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (flush)                r_llbit <= 1'b0;
      else if (w_cpl_ll)        r_llbit <= 1'b1;
      else if (w_cpl_sc)        r_llbit <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    stallreq   = 1'b0;
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'd0;
    dbus_sel   = 4'd0;
    dbus_wdata = 32'd0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = (w_exc | ((w_is_load | w_is_store) & w_misalign)) ? 1'b0 : wreg_i;
      adel_o = w_is_load & w_misalign;
      ades_o = w_is_store & w_misalign;
      if (w_is_load)    wdata_o = w_load_data;
      else if (w_is_sc) wdata_o = (r_state == S_DONE) ? 32'd1 : {31'd0, r_llbit};
      else              wdata_o = wdata_i;

      unique case (r_state)
        S_IDLE: begin
          if (!flush && w_valid) begin
            dbus_req   = 1'b1;
            dbus_we    = w_is_store;
            dbus_addr  = w_addr;
            dbus_sel   = w_sel;
            dbus_wdata = w_wdata;
            stallreq   = 1'b1;
          end
        end
        S_BUSY, S_DRAIN: begin
          dbus_req   = 1'b1;
          dbus_we    = r_we;
          dbus_addr  = r_addr;
          dbus_sel   = r_sel;
          dbus_wdata = r_wdata;
          // While draining, only a fresh access presented behind the flush waits.
          stallreq   = (r_state == S_BUSY) ? 1'b1 : w_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [31:0] excepttype_i;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;
  logic        adel_o;
  logic        ades_o;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .excepttype_i(excepttype_i),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .adel_o(adel_o), .ades_o(ades_o),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  logic [31:0] mem [256];   // bus slave storage, word index = addr[9:2]
  bit          llbit_m;     // model of the link bit
  int          total  = 0;
  int          passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic present_nop();
    aluop_i      = 8'h00;
    wd_i         = 5'd0;
    wreg_i       = 1'b0;
    wdata_i      = 32'd0;
    mem_addr_i   = 32'd0;
    reg2_i       = 32'd0;
    excepttype_i = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({wd_o, wreg_o, stallreq, adel_o, ades_o, dbus_req, dbus_we, dbus_sel}), 32'd0);
    check({tag, "_wdata"}, wdata_o | dbus_addr | dbus_wdata, 32'd0);
  endtask

  // One pipeline instruction: present it, play bus slave with 'lat' wait
  // cycles before ack, and check everything once the stage stops stalling.
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] exc, input int lat);
    bit is_load, is_store, is_b, is_h, is_w, is_sc, mis, valid, fin;
    int reqs, stalls, cyc, bs;
    logic [31:0] w, exp_data, exp_wdata;
    logic [7:0]  b8;
    logic [15:0] h16;
    logic [3:0]  exp_sel;
    logic        exp_wreg;
    is_b     = (op == 8'hE0 || op == 8'hE4 || op == 8'hE8);
    is_h     = (op == 8'hE1 || op == 8'hE5 || op == 8'hE9);
    is_w     = (op == 8'hE3 || op == 8'hEB || op == 8'hF0 || op == 8'hF8);
    is_load  = (op == 8'hE0 || op == 8'hE1 || op == 8'hE3 || op == 8'hE4 || op == 8'hE5 || op == 8'hF0);
    is_store = (op == 8'hE8 || op == 8'hE9 || op == 8'hEB || op == 8'hF8);
    is_sc    = (op == 8'hF8);
    mis      = (is_h && a[0]) || (is_w && a[1:0] != 2'b00);
    valid    = (is_load || is_store) && !mis && exc == 0 && !(is_sc && !llbit_m);

    aluop_i = op; mem_addr_i = a; reg2_i = r2; excepttype_i = exc;
    wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
    exp_wreg = (exc != 0 || ((is_load || is_store) && mis)) ? 1'b0 : wreg_i;

    // expected lanes and data, straight from byte-address arithmetic
    bs = 3 - int'(a[1:0]);
    exp_sel   = is_b ? 4'(1 << bs) : is_h ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    exp_wdata = is_b ? {4{r2[7:0]}} : is_h ? {2{r2[15:0]}} : r2;
    w   = mem[a[9:2]];
    b8  = 8'(w >> (8 * bs));
    h16 = 16'(w >> (a[1] ? 0 : 16));
    case (op)
      8'hE0:   exp_data = 32'($signed(b8));
      8'hE4:   exp_data = {24'd0, b8};
      8'hE1:   exp_data = 32'($signed(h16));
      8'hE5:   exp_data = {16'd0, h16};
      8'hF8:   exp_data = valid ? 32'd1 : 32'd0;
      8'hE3, 8'hF0: exp_data = w;
      default: exp_data = wdata_i;
    endcase

    reqs = 0; stalls = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (dbus_req) begin
        reqs++;
        check("bus_addr", dbus_addr, {a[31:2], 2'b00});
        check("bus_sel", 32'(dbus_sel), 32'(exp_sel));
        check("bus_we", 32'(dbus_we), 32'(is_store));
        if (is_store) check("bus_wdata", dbus_wdata, exp_wdata);
        if (reqs == lat + 1) begin
          dbus_ack = 1'b1;
          if (dbus_we) begin
            for (int i = 0; i < 4; i++)
              if (dbus_sel[i]) mem[dbus_addr[9:2]][8*i +: 8] = dbus_wdata[8*i +: 8];
          end else begin
            dbus_rdata = mem[dbus_addr[9:2]];
          end
        end
      end
      if (!stallreq) begin
        fin = 1;
        check("done_req", 32'(dbus_req), 32'd0);
        check("wd_o", 32'(wd_o), 32'(wd_i));
        check("wreg_o", 32'(wreg_o), 32'(exp_wreg));
        check("adel_o", 32'(adel_o), 32'(is_load && mis));
        check("ades_o", 32'(ades_o), 32'(is_store && mis));
        if ((is_load && valid) || (is_sc && !mis && exc == 0) || !(is_load || is_store))
          check("wdata_o", wdata_o, exp_data);
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      dbus_ack   = 1'b0;
      dbus_rdata = $urandom;
    end
    check("finished", 32'(fin), 32'd1);
    check("stall_cycles", stalls, valid ? lat + 1 : 0);
    check("req_cycles", reqs, valid ? lat + 1 : 0);
    if (valid && op == 8'hF0) llbit_m = 1'b1;
    if (valid && is_sc)       llbit_m = 1'b0;
  endtask

  // Flush while the stage is idle: nothing may be issued, link bit drops.
  task automatic flush_idle();
    present_nop();
    aluop_i = 8'hE3; mem_addr_i = 32'h10;   // a would-be access, suppressed by flush
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_req", 32'(dbus_req), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    llbit_m = 1'b0;
  endtask

  localparam logic [7:0] OPS [11] = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8,
                                      8'hE9, 8'hEB, 8'hF0, 8'hF8, 8'h21};

  initial begin
    logic [31:0] ra;
    logic [7:0]  rop;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    llbit_m = 1'b0;
    flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    present_nop();
    // reset: outputs forced low even with an access presented
    rst = 1'b1;
    aluop_i = 8'hE3; mem_addr_i = 32'h100; wreg_i = 1'b1; wd_i = 5'd7; wdata_i = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outs");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. LW, 3 stall cycles
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    do_op(8'hE3, 32'h100, 32'd0, 32'd0, 2);
    // 2. LB / LBU at byte 3
    mem[32'h103 >> 2] = 32'h112233F0;
    do_op(8'hE0, 32'h103, 32'd0, 32'd0, 1);
    do_op(8'hE4, 32'h103, 32'd0, 32'd0, 0);
    // 3. SH to lower half
    do_op(8'hE9, 32'h202, 32'h1234ABCD, 32'd0, 1);
    check("sh_mem", mem[32'h200 >> 2] & 32'h0000FFFF, 32'h0000ABCD);
    // 4. misaligned
    do_op(8'hE3, 32'h101, 32'd0, 32'd0, 0);
    do_op(8'hEB, 32'h102, 32'h0, 32'd0, 0);
    // exception suppresses
    do_op(8'hE3, 32'h100, 32'd0, 32'h8, 0);
    // non-memory passthrough
    do_op(8'h21, 32'h104, 32'd0, 32'd0, 0);
    // 5. LL/SC
    do_op(8'hF0, 32'h40, 32'd0, 32'd0, 1);
    do_op(8'hF8, 32'h40, 32'hCAFE0001, 32'd0, 1);
    do_op(8'hF8, 32'h40, 32'hCAFE0002, 32'd0, 0);
    do_op(8'hF0, 32'h40, 32'd0, 32'd0, 0);
    flush_idle();
    do_op(8'hF8, 32'h40, 32'hCAFE0003, 32'd0, 0);

    // 6a. flush in BUSY, new LW presented while draining
    do_op(8'hF0, 32'h40, 32'd0, 32'd0, 0);
    present_nop();
    aluop_i = 8'hE3; mem_addr_i = 32'h300; wreg_i = 1'b1;
    @(negedge clk);
    check("drain_issue", 32'({dbus_req, stallreq}), 32'b11);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("drain_busy_flush", 32'({dbus_req, stallreq}), 32'b11);
    check("drain_addr0", dbus_addr, 32'h300);
    @(posedge clk); #1;
    flush = 1'b0; llbit_m = 1'b0;
    mem_addr_i = 32'h304;
    @(negedge clk);
    check("drain_hold", 32'({dbus_req, stallreq}), 32'b11);
    check("drain_addr1", dbus_addr, 32'h300);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_addr2", dbus_addr, 32'h300);
    dbus_ack = 1'b1; dbus_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    do_op(8'hE3, 32'h304, 32'd0, 32'd0, 0);
    // link bit was cleared by that flush
    do_op(8'hF8, 32'h40, 32'h1, 32'd0, 0);

    // 6b. reset in BUSY abandons access and clears the link bit
    do_op(8'hF0, 32'h80, 32'd0, 32'd0, 0);
    present_nop();
    aluop_i = 8'hE3; mem_addr_i = 32'h10; wreg_i = 1'b1;
    @(negedge clk);
    check("rst_busy_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    present_nop();
    @(negedge clk);
    check_all_zero("rst_during");
    @(posedge clk); #1;
    rst = 1'b0; llbit_m = 1'b0;
    @(negedge clk);
    check_all_zero("rst_after");
    @(posedge clk); #1;
    do_op(8'hF8, 32'h80, 32'h1, 32'd0, 0);

    // randomized stream
    for (int n = 0; n < 60; n++) begin
      rop = OPS[$urandom_range(0, 10)];
      if ($urandom_range(0, 3) == 0) rop = 8'hF0;
      ra = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) ra = ra & ~32'h3;
      if ($urandom_range(0, 11) == 0) flush_idle();
      do_op(rop, ra, $urandom, ($urandom_range(0, 9) == 0) ? 32'h10 : 32'd0,
            $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
